param_fifo: RTL and testbench
=============================

Name: param_fifo

Overview:
Parametrised single-clock synchronous FIFO. It is the next-generation byte/word buffer between the UART/command front end and the glitch sequencer. It generalises data width and depth and adds full/almost-full flags, an occupancy count, overflow and underflow protection, a read-valid strobe and a synchronous flush. Writes are never silently lost or corrupted.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush; empties FIFO
in  input  WIDTH  write data
add  input  1  write request, sampled each cycle
get  input  1  read request, sampled each cycle
out  output  WIDTH  read data, registered
out_valid  output  1  one-cycle strobe: out holds a newly read word
available  output  1  FIFO non-empty (count != 0)
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- One clock: clk. Reset rst_n is asynchronous and active-low. Assertion immediately clears wr_ptr, rd_ptr, count, out, out_valid, overflow and underflow to 0. available, full and almost_full therefore read 0. Storage array is not reset. Deassertion is synchronised externally.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately, so full and empty are unambiguous.
- Write accept: wr_ok = add & (!full | rd_ok). On wr_ok, mem[wr_ptr] <= in and wr_ptr++.
- Read accept: rd_ok = get & (count != 0). There is no write-to-read bypass. On rd_ok, out <= mem[rd_ptr] and rd_ptr++.
- Read latency: out_valid is 1 in the cycle after rd_ok and 0 otherwise. out holds its last value when no read occurs.
- count update: count <= count + wr_ok - rd_ok.
- Flags are combinational from registered count. They reflect the state after the last edge.
- Full and add&get together: both are accepted and count stays DEPTH. No overflow.
- Empty and add&get together: the write is accepted, the read is rejected, count becomes 1 and underflow pulses.
- overflow <= add & !wr_ok. underflow <= get & !rd_ok. Both are registered and high for exactly one cycle per rejected request.
- clr, synchronous, has priority over add/get in the same cycle:
  - clears wr_ptr, rd_ptr, count, out_valid, overflow and underflow next edge.
  - out keeps its value.
  - requests presented in the clr cycle are discarded without an overflow/underflow pulse.
- Reset mid-operation: all state is lost immediately. The first write after release lands at index 0.
- Data ordering: strict first-in first-out. No word is duplicated or skipped across pointer wrap.

Test Plan:
- Reset, WIDTH=8, DEPTH=8: assert rst_n=0 mid-stream -> count=0, available=0, full=0, out=0, out_valid=0 within the same cycle, without waiting for a clk edge.
- Write 0x11..0x88 on 8 consecutive cycles, then a 9th write 0x99 -> full=1, count=8, almost_full=1 from count=6. The 0x99 write gives overflow=1 for one cycle, and 0x99 is never read.
- Drain the full FIFO with get held 9 cycles -> out=0x11..0x88 in order, each with out_valid=1 one cycle after its get. 9th get -> underflow pulse, out stays 0x88, out_valid=0.
- Wrap: write 5, read 5, then write 6 values 0xA0..0xA5 and read 6 -> order preserved across the index 7->0 wrap; count peaks at 6.
- Simultaneous ops: at full, add=get=1 with in=0xC3 -> count stays 8, no overflow, 0xC3 emerges after the 8 older words. At empty, add=get=1 -> count=1, underflow=1.
- Flush: with count=4, pulse clr together with add=1 -> next cycle count=0, available=0, no overflow. A subsequent write then read returns that new word.

Source files
------------

// File: rtl/param_fifo.sv
// ============================================================================
// Module   : param_fifo
// Brief    : Single-clock synchronous FIFO with occupancy count, full/almost-
//            full flags, overflow/underflow pulses, read-valid strobe, flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         in,
    input  logic                     add,
    input  logic                     get,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    output logic                     available,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;
    logic [WIDTH-1:0]   r_out_q, w_out_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic               r_overflow_q, w_overflow_d;
    logic               r_underflow_q, w_underflow_d;

    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_full;

    assign w_full = (r_count_q == c_CNT_W'(DEPTH));

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        w_rd_ok = get && (r_count_q != '0);
        w_wr_ok = add && (!w_full || w_rd_ok);

        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;
        w_out_d       = r_out_q;
        w_out_valid_d = w_rd_ok;
        w_overflow_d  = add && !w_wr_ok;
        w_underflow_d = get && !w_rd_ok;

        if (clr) begin
            w_wr_ptr_d    = '0;
            w_rd_ptr_d    = '0;
            w_count_d     = '0;
            w_out_valid_d = 1'b0;
            w_overflow_d  = 1'b0;
            w_underflow_d = 1'b0;
        end else begin
            if (w_wr_ok) begin
                w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
            end
            if (w_rd_ok) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
                w_out_d    = r_mem[r_rd_ptr_q];
            end
            w_count_d = r_count_q + c_CNT_W'(w_wr_ok) - c_CNT_W'(w_rd_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_count_q     <= '0;
            r_out_q       <= '0;
            r_out_valid_q <= 1'b0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_count_q     <= w_count_d;
            r_out_q       <= w_out_d;
            r_out_valid_q <= w_out_valid_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    // Storage carries no reset; a flushed cycle must not write either.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !clr) begin
            r_mem[r_wr_ptr_q] <= in;
        end
    end

    assign out         = r_out_q;
    assign out_valid   = r_out_valid_q;
    assign available   = (r_count_q != '0);
    assign full        = w_full;
    assign almost_full = (r_count_q >= c_CNT_W'(AF_LEVEL));
    assign count       = r_count_q;
    assign overflow    = r_overflow_q;
    assign underflow   = r_underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_param_fifo.sv
// ============================================================================
// Module   : tb_param_fifo
// Brief    : Directed and randomized checks of param_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic [WIDTH-1:0] in_data;
    logic             add;
    logic             get;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             available;
    logic             full;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    param_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in          (in_data),
        .add         (add),
        .get         (get),
        .out         (out),
        .out_valid   (out_valid),
        .available   (available),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    logic             m_ovf;
    logic             m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " count"},       32'(count),       32'(m_q.size()));
        check({tag, " available"},   32'(available),   32'(m_q.size() != 0));
        check({tag, " full"},        32'(full),        32'(m_q.size() == DEPTH));
        check({tag, " almost_full"}, 32'(almost_full), 32'(m_q.size() >= AF_LEVEL));
        check({tag, " out"},         32'(out),         32'(m_out));
        check({tag, " out_valid"},   32'(out_valid),   32'(m_valid));
        check({tag, " overflow"},    32'(overflow),    32'(m_ovf));
        check({tag, " underflow"},   32'(underflow),   32'(m_udf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model over the same edge, then compare.
    task automatic step(input string tag, input logic a, input logic g, input logic c,
                        input logic [WIDTH-1:0] d);
        int  n;
        bit  rd;
        bit  wr;
        add     = a;
        get     = g;
        clr     = c;
        in_data = d;
        n       = m_q.size();
        @(posedge clk);
        if (c) begin
            m_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            rd = g && (n > 0);
            wr = a && ((n < DEPTH) || rd);
            if (rd) m_out = m_q.pop_front();
            if (wr) m_q.push_back(d);
            m_valid = rd;
            m_ovf   = a && !wr;
            m_udf   = g && !rd;
        end
        #1;
        add = 1'b0;
        get = 1'b0;
        clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int phase_add;
        int phase_get;
        rst_n   = 1'b0;
        clr     = 1'b0;
        add     = 1'b0;
        get     = 1'b0;
        in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill past capacity: the ninth word must be rejected.
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 1'b0, WIDTH'((i + 1) * 8'h11));
        step("fill_over", 1'b1, 1'b0, 1'b0, 8'h99);
        step("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 9; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
        step("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Pointer wrap through index 7 -> 0.
        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, 1'b0, WIDTH'(8'h30 + i));
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step("wrap_w6", 1'b1, 1'b0, 1'b0, WIDTH'(8'hA0 + i));
        for (int i = 0; i < 6; i++) step("wrap_r6", 1'b0, 1'b1, 1'b0, 8'h00);

        // Simultaneous add/get at full and at empty.
        for (int i = 0; i < 8; i++) step("sim_fill", 1'b1, 1'b0, 1'b0, WIDTH'(8'h50 + i));
        step("sim_full", 1'b1, 1'b1, 1'b0, 8'hC3);
        for (int i = 0; i < 8; i++) step("sim_drain", 1'b0, 1'b1, 1'b0, 8'h00);
        step("sim_empty", 1'b1, 1'b1, 1'b0, 8'h77);
        step("sim_rd", 1'b0, 1'b1, 1'b0, 8'h00);

        // Flush with a concurrent write.
        for (int i = 0; i < 4; i++) step("fl_fill", 1'b1, 1'b0, 1'b0, WIDTH'(8'h60 + i));
        step("flush", 1'b1, 1'b0, 1'b1, 8'hEE);
        step("fl_w", 1'b1, 1'b0, 1'b0, 8'h5A);
        step("fl_r", 1'b0, 1'b1, 1'b0, 8'h00);
        step("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-stream, checked before any clock edge.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, WIDTH'(8'h40 + i));
        step("pre_rst_r", 1'b0, 1'b1, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_w", 1'b1, 1'b0, 1'b0, 8'hB1);
        step("post_rst_r", 1'b0, 1'b1, 1'b0, 8'h00);

        // Randomized traffic with drifting add/get bias to visit full and empty often.
        phase_add = 50;
        phase_get = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                phase_add = $urandom_range(10, 90);
                phase_get = $urandom_range(10, 90);
            end
            step("rand",
                 1'($urandom_range(0, 99) < phase_add),
                 1'($urandom_range(0, 99) < phase_get),
                 1'($urandom_range(0, 63) == 0),
                 WIDTH'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
